shift_exec_stage: RTL
=====================

Name: shift_exec_stage

Overview:
- Registered execute-stage wrapper around the team's combinational barrel shifters (sll, sra).
- Accepts shift micro-ops from decode/issue over a valid/ready handshake and computes the result in the accept cycle.
- Buffers results in a 2-entry skid FIFO and presents them to writeback over a second valid/ready handshake.
- Decouples shifter timing from writeback stalls and sustains one op per cycle at full throughput.

Parameters:
- WIDTH, 32, datapath width; the shift amount is fixed at 5 bits.
- TAGW, 5, destination-register tag width.
- DEPTH, 2, skid FIFO entries; only 2 is supported.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: 0 = reset asserted.
- flush  input  1  synchronous pipeline flush; active high.
- in_valid  input  1  op presented by issue.
- in_ready  output  1  stage can accept an op this cycle.
- in_op  input  2  00 SLL, 01 SRA, 10 SRL, 11 reserved (pass-through).
- in_data  input  WIDTH  operand A.
- in_shamt  input  5  shift amount 0..31.
- in_tag  input  TAGW  destination tag; carried unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  writeback consumes the result.
- out_result  output  WIDTH  head result.
- out_tag  output  TAGW  head tag.
- out_zero  output  1  out_result == 0.
- op_count  output  16  number of completed pops, wrapping.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFO count = 0; read and write pointers = 0; op_count = 0.
  - out_valid = 0; out_result = 0; out_tag = 0; out_zero = 1.
  - in_ready = 1 from the first cycle after deassertion.
  - Reset mid-operation discards all buffered ops.
- Push: occurs on a rising edge where in_valid && in_ready && !flush. The entry written is {result, tag}.
- Result computation (combinational from the inputs, width preserved):
  - SLL: in_data << in_shamt, zero fill.
  - SRA: arithmetic right shift, replicating in_data[WIDTH-1].
  - SRL: logical right shift, zero fill.
  - 11: in_data unchanged.
  - shamt = 0 returns in_data for every op.
- Latency: an op pushed at edge N is visible on out_* from immediately after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Pop: occurs on a rising edge where out_valid && out_ready && !flush. op_count increments on each pop and wraps 0xFFFF -> 0.
- out_valid = (count != 0). out_result, out_tag and out_zero come from the head entry.
  - While out_valid = 0 these outputs hold their last values. Verification ignores them in that state.
- in_ready = (count < DEPTH). It depends only on registered count, never combinationally on out_ready.
- Count updates:
  - push only: count + 1.
  - pop only: count - 1.
  - push and pop in the same cycle (possible only at count 1): count stays 1; both pointers advance.
  - count = 2: in_ready = 0, no push; a pop that cycle brings count to 1.
  - count = 0: a pop is impossible because out_valid = 0.
- Pointers are 1 bit each and wrap 1 -> 0.
- Flush (synchronous):
  - On an edge with flush = 1, count and both pointers clear to 0.
  - Any push or pop presented that cycle is discarded; op_count is not incremented.
  - out_valid = 0 and in_ready = 1 in the following cycle.
- Ordering: strict FIFO; tags leave in acceptance order.
- Outputs are driven only from FIFO storage, so there is no combinational in -> out path.

Decomposition:
- Shared package / header `shift_defs`:
  - op encodings OP_SLL = 2'b00, OP_SRA = 2'b01, OP_SRL = 2'b10, OP_PASS = 2'b11.
  - WIDTH and TAGW defaults.
- One natural sub-module: shift_skid_fifo, a 2-entry FIFO with count, pointers, flush and payload {WIDTH+TAGW}.
- The top level instantiates the team's sll and sra shifters. SRL is derived from the sra datapath with the sign input forced to 0.
- The top level adds the op mux, handshake glue and op_count.

Test Plan:
- Reset then single op: SRA, in_data 0x80000000, shamt 4, tag 3, out_ready = 1 -> next cycle out_valid = 1, out_result 0xF8000000, out_tag 3, out_zero = 0; op_count = 1 after the pop edge.
- Op mix: SLL 0x00000001 sh 31 -> 0x80000000; SRL 0x80000000 sh 31 -> 0x00000001; SRA 0x7FFFFFF0 sh 4 -> 0x07FFFFFF; PASS 0x12345678 -> unchanged; SLL 0xFFFFFFFF sh 0 -> 0xFFFFFFFF.
- Backpressure: out_ready = 0 while pushing 3 ops (tags 1, 2, 3) -> in_ready drops to 0 after 2 accepts and tag 3 is held at the input; raise out_ready -> tags emerge 1, 2, 3 in order, none lost or duplicated.
- Throughput: 20 back-to-back ops with out_ready = 1 -> in_ready stays 1, 20 results on 20 consecutive cycles, op_count = 20.
- Flush: with count = 2, assert flush together with in_valid -> next cycle out_valid = 0, in_ready = 1, the flush-cycle op is absent, op_count unchanged.
- Async reset mid-stream: drop reset between clock edges with count = 1 -> out_valid falls immediately, op_count = 0; after release, a new SRL 0xF0000000 sh 28 -> 0x0000000F with out_zero = 0; SLL 0x1 sh 32-wrap-free case 0x0 sh 5 -> out_zero = 1.

Source files
------------

// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the shift execute stage.
// Contents:
//   SHIFT_WIDTH / SHIFT_TAGW / SHAMT_W : default datapath, tag and shift-amount widths
//   shift_op_e                         : micro-op encoding presented on in_op
package shift_exec_stage_pkg;

  localparam int SHIFT_WIDTH = 32;
  localparam int SHIFT_TAGW  = 5;
  localparam int SHAMT_W     = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_SRL  = 2'b10,
    OP_PASS = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_barrel.sv
// Combinational barrel shifters used by the execute stage.
//   sll : data_i << shamt_i, zero fill.
//   sra : right shift filling vacated bits with fill_i. Drive fill_i with the
//         operand MSB for an arithmetic shift, or 0 for a logical shift.
// Ports: data_i (operand), shamt_i (amount 0..31), fill_i (sra only),
//        result_o (shifted value, same width as data_i).
module sll
  import shift_exec_stage_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   result_o
);

  assign result_o = data_i << shamt_i;

endmodule

module sra
  import shift_exec_stage_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               fill_i,
  output logic [WIDTH-1:0]   result_o
);

  // Prepend a word of fill bits, shift right, keep the low word: the fill
  // bits slide in from the top exactly as a sign extension would.
  logic [2*WIDTH-1:0] ext;

  assign ext      = {{WIDTH{fill_i}}, data_i};
  assign result_o = WIDTH'(ext >> shamt_i);

endmodule

// File: rtl/shift_skid_fifo.sv
// Two-entry FIFO buffering {result, tag} between the shifter and writeback.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : synchronous clear of count and pointers; overrides push/pop
//   push_i, wdata_i : write request and payload (ignored when full)
//   pop_i           : read request (ignored when empty)
//   rdata_o         : head entry
//   count_o         : occupancy 0..2
module shift_skid_fifo #(
  parameter int PW = 37
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [PW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [PW-1:0] rdata_o,
  output logic [1:0]    count_o
);

  logic [PW-1:0] mem_q [2];
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  // A flushed cycle neither writes nor reads.
  assign push_ok = push_i && (count_q != 2'd2) && !flush_i;
  assign pop_ok  = pop_i  && (count_q != 2'd0) && !flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/shift_exec_stage.sv
// Registered execute stage for shift micro-ops.
// Ports:
//   clock, reset (async, active low), flush (sync, active high)
//   in_valid/in_ready, in_op, in_data, in_shamt, in_tag : issue side
//   out_valid/out_ready, out_result, out_tag, out_zero  : writeback side
//   op_count : completed pops, wrapping at 16 bits
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high and flush is low. in_ready depends only on registered occupancy
// (count < DEPTH) and out_valid only on occupancy (count != 0), so neither
// ready/valid output is a combinational function of the other side.
// The result is computed in the accept cycle and written to the FIFO; all
// out_* signals come from FIFO storage.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int TAGW  = SHIFT_TAGW,
  parameter int DEPTH = 2            // only 2 is supported
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAGW-1:0]    in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAGW-1:0]    out_tag,
  output logic               out_zero,
  output logic [15:0]        op_count
);

  logic [WIDTH-1:0]      sll_res;
  logic [WIDTH-1:0]      sr_res;
  logic                  sr_fill;
  logic [WIDTH-1:0]      result;
  logic [WIDTH+TAGW-1:0] head;
  logic [1:0]            count;
  logic                  push, pop;
  logic [15:0]           op_count_q, op_count_d;

  sll #(.WIDTH(WIDTH)) u_sll (
    .data_i   (in_data),
    .shamt_i  (in_shamt),
    .result_o (sll_res)
  );

  // One right shifter serves both SRA and SRL; only the fill bit differs.
  assign sr_fill = (in_op == OP_SRA) ? in_data[WIDTH-1] : 1'b0;

  sra #(.WIDTH(WIDTH)) u_sra (
    .data_i   (in_data),
    .shamt_i  (in_shamt),
    .fill_i   (sr_fill),
    .result_o (sr_res)
  );

  always_comb begin
    result = in_data;
    case (in_op)
      OP_SLL:  result = sll_res;
      OP_SRA:  result = sr_res;
      OP_SRL:  result = sr_res;
      default: result = in_data;
    endcase
  end

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  shift_skid_fifo #(.PW(WIDTH + TAGW)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({result, in_tag}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  assign in_ready   = (count < 2'(DEPTH));
  assign out_valid  = (count != 2'd0);
  assign out_result = head[WIDTH+TAGW-1:TAGW];
  assign out_tag    = head[TAGW-1:0];
  assign out_zero   = (out_result == '0);

  assign op_count_d = (pop && !flush) ? op_count_q + 16'd1 : op_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) op_count_q <= 16'd0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;

endmodule
